// File: rtl/uart_cmd_ctrl_if.sv
// Bus bundle between the UART command controller and its RX FIFO, TX FIFO and register file.
// A flop that the interface does not expose is visible only through o_dbg_state.
interface uart_cmd_ctrl_if;
    // Handshakes: RX is first-word-fall-through, so i_rx_data is valid whenever
    // i_rx_fifo_e is low, and an o_rx_rd pulse consumes it at that clock edge.
    // o_tx_wr pushes o_tx_data on that clock edge and pulses only while
    // i_tx_fifo_f is low. o_wr_req and o_rd_req are single-cycle strobes that
    // qualify o_rwaddr. i_read_data is sampled in the cycle after o_rd_req.
    logic       i_rx_fifo_e;
    logic [7:0] i_rx_data;
    logic       o_rx_rd;
    logic       i_tx_fifo_f;
    logic       o_tx_wr;
    logic [7:0] o_tx_data;
    logic [2:0] o_rwaddr;
    logic [7:0] o_write_data;
    logic       o_wr_req;
    logic       o_rd_req;
    logic [7:0] i_read_data;
    logic       i_err_clr;
    logic       o_busy;
    logic [7:0] o_err_cnt;
    logic [2:0] o_dbg_state;

    modport master (
        input  i_rx_fifo_e, i_rx_data, i_tx_fifo_f, i_read_data, i_err_clr,
        output o_rx_rd, o_tx_wr, o_tx_data, o_rwaddr, o_write_data,
               o_wr_req, o_rd_req, o_busy, o_err_cnt, o_dbg_state
    );

    modport slave (
        output i_rx_fifo_e, i_rx_data, i_tx_fifo_f, i_read_data, i_err_clr,
        input  o_rx_rd, o_tx_wr, o_tx_data, o_rwaddr, o_write_data,
               o_wr_req, o_rd_req, o_busy, o_err_cnt, o_dbg_state
    );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes command bytes from a UART RX FIFO into register-file reads and writes;
// read results are returned through the TX FIFO. Malformed commands and write timeouts are counted.
module uart_cmd_ctrl #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input logic            i_clk,
    input logic            i_rst,
    uart_cmd_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_DECODE    = 3'd1,
        S_WAIT_DATA = 3'd2,
        S_WR        = 3'd3,
        S_RD_REQ    = 3'd4,
        S_RD_CAP    = 3'd5,
        S_TX_WAIT   = 3'd6
    } state_t;

    localparam int            CW      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [7:0]    cmd_q, cmd_d;
    logic [CW-1:0] to_cnt_q, to_cnt_d;
    logic [2:0]    rwaddr_q, rwaddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    txdata_q, txdata_d;
    logic [7:0]    err_q, err_d;
    logic          err_inc;
    logic          rx_rd, tx_wr, wr_req, rd_req;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= 8'h00;
            to_cnt_q <= '0;
            rwaddr_q <= 3'd0;
            wdata_q  <= 8'h00;
            txdata_q <= 8'h00;
            err_q    <= 8'h00;
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            to_cnt_q <= to_cnt_d;
            rwaddr_q <= rwaddr_d;
            wdata_q  <= wdata_d;
            txdata_q <= txdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        to_cnt_d = to_cnt_q;
        rwaddr_d = rwaddr_q;
        wdata_d  = wdata_q;
        txdata_d = txdata_q;
        err_inc  = 1'b0;
        rx_rd    = 1'b0;
        tx_wr    = 1'b0;
        wr_req   = 1'b0;
        rd_req   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!bus.i_rx_fifo_e) begin
                    rx_rd   = 1'b1;
                    cmd_d   = bus.i_rx_data;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (cmd_q[6:3] != 4'd0) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else if (cmd_q[7]) begin
                    to_cnt_d = '0;
                    state_d  = S_WAIT_DATA;
                end else begin
                    // Address is loaded one cycle early so it is stable under o_rd_req.
                    rwaddr_d = cmd_q[2:0];
                    state_d  = S_RD_REQ;
                end
            end
            S_WAIT_DATA: begin
                // An arriving byte takes priority over the final timeout cycle.
                if (!bus.i_rx_fifo_e) begin
                    rx_rd    = 1'b1;
                    wdata_d  = bus.i_rx_data;
                    rwaddr_d = cmd_q[2:0];
                    state_d  = S_WR;
                end else if (to_cnt_q == TO_LAST) begin
                    err_inc = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CW'(1);
                end
            end
            S_WR: begin
                wr_req  = 1'b1;
                state_d = S_IDLE;
            end
            S_RD_REQ: begin
                rd_req  = 1'b1;
                state_d = S_RD_CAP;
            end
            S_RD_CAP: begin
                txdata_d = bus.i_read_data;
                state_d  = S_TX_WAIT;
            end
            S_TX_WAIT: begin
                if (!bus.i_tx_fifo_f) begin
                    tx_wr   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A clear in the same cycle as a new error leaves exactly that error counted.
        if (bus.i_err_clr) begin
            err_d = err_inc ? 8'd1 : 8'd0;
        end else if (err_inc && (err_q != 8'hFF)) begin
            err_d = err_q + 8'd1;
        end else begin
            err_d = err_q;
        end
    end

    // The pop strobe sees the live FIFO flag, so it is masked while reset holds the FSM in IDLE.
    assign bus.o_rx_rd      = rx_rd & ~i_rst;
    assign bus.o_tx_wr      = tx_wr;
    assign bus.o_wr_req     = wr_req;
    assign bus.o_rd_req     = rd_req;
    assign bus.o_tx_data    = txdata_q;
    assign bus.o_rwaddr     = rwaddr_q;
    assign bus.o_write_data = wdata_q;
    assign bus.o_err_cnt    = err_q;
    assign bus.o_busy       = (state_q != S_IDLE);
    assign bus.o_dbg_state  = state_q;
endmodule
